// File: rtl/pb_mode_controller.sv
// ---------------------------------------------------------------------------
// pb_mode_controller
//
// Pushbutton front end and command sequencer between the board pb[] pins and
// the datapath/display logic. Each raw button passes through a two-flop
// synchroniser, a stable-count debouncer and a rising-edge pulse generator.
// The debounced pulses then step an IDLE -> WRITE -> READ -> CLEAR mode FSM
// that issues increment/decrement commands, steps the output selector and
// produces a one-cycle clear pulse. An optional hold-to-repeat re-issues the
// increment/decrement command while its button stays held in WRITE.
//
// Button roles: pb[0]=mode, pb[1]=select, pb[2]=increment, pb[3]=decrement.
// Buttons with index >= 4 only produce btn_pulse.
//
// Ports
//   hwclk             in   system clock, rising edge
//   reset             in   asynchronous, active-high reset
//   pb                in   raw asynchronous buttons, active high
//   btn_pulse         out  debounced rising-edge pulses, one cycle each
//   clear             out  high for the single cycle spent in CLEAR
//   write             out  high while in WRITE
//   read              out  high while in READ
//   enable_increment  out  one-cycle increment command (WRITE only)
//   enable_decrement  out  one-cycle decrement command (WRITE only)
//   output_select     out  selected output channel
//   mode              out  state code: IDLE=0, WRITE=1, READ=2, CLEAR=3
// ---------------------------------------------------------------------------
module pb_mode_controller #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int REPEAT_CYCLES   = 0,
  parameter int SEL_W           = 2
) (
  input  logic               hwclk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] pb,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic               clear,
  output logic               write,
  output logic               read,
  output logic               enable_increment,
  output logic               enable_decrement,
  output logic [SEL_W-1:0]   output_select,
  output logic [1:0]         mode
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam int RP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RP_W-1:0] RP_LAST = (REPEAT_CYCLES > 0) ? RP_W'(REPEAT_CYCLES - 1) : '0;
  localparam logic REPEAT_EN = (REPEAT_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    CLEAR = 2'd3
  } state_t;

  state_t state;

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] db_level;
  logic [NUM_BTN-1:0] db_prev;
  logic [DB_W-1:0]    db_cnt [NUM_BTN];

  logic            rep_active;
  logic            rep_dir;
  logic [RP_W-1:0] rep_cnt;
  logic            rep_held;

  // Input path. The counter only runs while the synchronised level disagrees
  // with the accepted level; the level flips on the DEBOUNCE_CYCLES-th
  // consecutive disagreeing cycle. The pulse compares the accepted level with
  // its one-cycle-old copy, so it lands one cycle after the flip.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      db_level  <= '0;
      db_prev   <= '0;
      btn_pulse <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1     <= pb;
      sync2     <= sync1;
      db_prev   <= db_level;
      btn_pulse <= db_level & ~db_prev;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2[i] == db_level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_level[i] <= ~db_level[i];
          db_cnt[i]   <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // The repeating button must still be the only one of inc/dec held down.
  assign rep_held = rep_dir ? (db_level[3] & ~db_level[2])
                            : (db_level[2] & ~db_level[3]);

  // Mode FSM with registered commands. A mode pulse always wins over any
  // other pulse in the same cycle; inc and dec together cancel each other.
  // An accepted inc/dec press arms the repeat counter, which re-issues the
  // same command every REPEAT_CYCLES cycles while the button stays held.
  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      enable_increment <= 1'b0;
      enable_decrement <= 1'b0;
      output_select    <= '0;
      rep_active       <= 1'b0;
      rep_dir          <= 1'b0;
      rep_cnt          <= '0;
    end else begin
      enable_increment <= 1'b0;
      enable_decrement <= 1'b0;
      case (state)
        IDLE: begin
          rep_active <= 1'b0;
          if (btn_pulse[0]) begin
            state <= WRITE;
          end
        end
        WRITE: begin
          if (btn_pulse[0]) begin
            state      <= READ;
            rep_active <= 1'b0;
          end else if (btn_pulse[2] ^ btn_pulse[3]) begin
            enable_increment <= btn_pulse[2];
            enable_decrement <= btn_pulse[3];
            rep_active       <= REPEAT_EN;
            rep_dir          <= btn_pulse[3];
            rep_cnt          <= '0;
          end else if (btn_pulse[2] & btn_pulse[3]) begin
            rep_active <= 1'b0;
          end else if (rep_active) begin
            if (!rep_held) begin
              rep_active <= 1'b0;
            end else if (rep_cnt == RP_LAST) begin
              rep_cnt <= '0;
              if (rep_dir) begin
                enable_decrement <= 1'b1;
              end else begin
                enable_increment <= 1'b1;
              end
            end else begin
              rep_cnt <= rep_cnt + RP_W'(1);
            end
          end
        end
        READ: begin
          rep_active <= 1'b0;
          if (btn_pulse[0]) begin
            state <= CLEAR;
          end else if (btn_pulse[1]) begin
            output_select <= output_select + SEL_W'(1);
          end
        end
        CLEAR: begin
          rep_active    <= 1'b0;
          state         <= IDLE;
          output_select <= '0;
        end
        default: begin
          rep_active <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign mode  = state;
  assign write = (state == WRITE);
  assign read  = (state == READ);
  assign clear = (state == CLEAR);

endmodule

// File: tb/tb_pb_mode_controller.sv
// ---------------------------------------------------------------------------
// tb_pb_mode_controller
//
// Directed bench for pb_mode_controller with DEBOUNCE_CYCLES=4,
// REPEAT_CYCLES=5, SEL_W=2. Each stimulus drives a button mask just after a
// clock edge, optionally releases it after a number of cycles, and records
// what the outputs did cycle by cycle (cycle k = values seen just after the
// k-th edge following the drive). Expected values are hand-derived timings.
// ---------------------------------------------------------------------------
module tb_pb_mode_controller;

  logic       hwclk;
  logic       reset;
  logic [3:0] pb;
  logic [3:0] btn_pulse;
  logic       clear;
  logic       write;
  logic       read;
  logic       enable_increment;
  logic       enable_decrement;
  logic [1:0] output_select;
  logic [1:0] mode;

  int testsRun;
  int testsFailed;

  int pulseCount [4];
  int pulseFirst [4];
  int incCount;
  int decCount;
  int clearCount;
  int mode3Count;
  int writeFirst;
  int incTimes [$];

  pb_mode_controller #(
    .NUM_BTN         (4),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_CYCLES   (5),
    .SEL_W           (2)
  ) dut (
    .hwclk            (hwclk),
    .reset            (reset),
    .pb               (pb),
    .btn_pulse        (btn_pulse),
    .clear            (clear),
    .write            (write),
    .read             (read),
    .enable_increment (enable_increment),
    .enable_decrement (enable_decrement),
    .output_select    (output_select),
    .mode             (mode)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive mask now (just after an edge), release after 'hold' cycles
  // (0 = keep driving), and record activity over ncyc cycles.
  task automatic applyStimulus(input logic [3:0] mask, input int hold, input int ncyc);
    for (int b = 0; b < 4; b++) begin
      pulseCount[b] = 0;
      pulseFirst[b] = -1;
    end
    incCount   = 0;
    decCount   = 0;
    clearCount = 0;
    mode3Count = 0;
    writeFirst = -1;
    incTimes.delete();
    pb = mask;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge hwclk);
      #1;
      for (int b = 0; b < 4; b++) begin
        if (btn_pulse[b]) begin
          pulseCount[b]++;
          if (pulseFirst[b] < 0) pulseFirst[b] = k;
        end
      end
      if (enable_increment) begin
        incCount++;
        incTimes.push_back(k);
      end
      if (enable_decrement) decCount++;
      if (clear) clearCount++;
      if (mode == 2'd3) mode3Count++;
      if (write && writeFirst < 0) writeFirst = k;
      if (k == hold) pb = '0;
    end
  endtask

  task automatic tap(input logic [3:0] mask);
    applyStimulus(mask, 5, 20);
  endtask

  int selExp [5] = '{1, 2, 3, 0, 1};

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    pb          = '0;
    reset       = 1'b1;

    repeat (3) @(posedge hwclk);
    #1;
    checkOutput("reset_outputs",
                int'({btn_pulse, clear, write, read, enable_increment,
                      enable_decrement, output_select, mode}), 0);
    reset = 1'b0;

    // Glitch shorter than the debounce window produces nothing.
    applyStimulus(4'b0100, 3, 15);
    checkOutput("glitch_no_pulse", pulseCount[2], 0);

    // Held mode button: pulse exactly at cycle 7, WRITE from cycle 8.
    applyStimulus(4'b0001, 0, 20);
    checkOutput("latency_pulse_cycle", pulseFirst[0], 7);
    checkOutput("latency_pulse_count", pulseCount[0], 1);
    checkOutput("latency_write_cycle", writeFirst, 8);
    checkOutput("latency_mode_write", mode, 1);
    applyStimulus(4'b0000, 0, 12);
    checkOutput("release_no_pulse", pulseCount[0], 0);
    checkOutput("release_mode_write", mode, 1);

    // Full cycle: WRITE -> READ -> CLEAR -> IDLE.
    tap(4'b0001);
    checkOutput("cycle_mode_read", mode, 2);
    checkOutput("cycle_read_flag", read, 1);
    tap(4'b0001);
    checkOutput("cycle_clear_cycles", clearCount, 1);
    checkOutput("cycle_mode3_cycles", mode3Count, 1);
    checkOutput("cycle_mode_idle", mode, 0);

    // Select wrap in READ, then CLEAR zeroes the selector.
    tap(4'b0001);
    tap(4'b0001);
    checkOutput("sel_in_read", mode, 2);
    for (int s = 0; s < 5; s++) begin
      tap(4'b0010);
      checkOutput($sformatf("sel_step%0d", s), output_select, selExp[s]);
    end
    tap(4'b0001);
    checkOutput("sel_clear_mode", mode, 0);
    checkOutput("sel_cleared", output_select, 0);

    // Increment gating by mode.
    tap(4'b0100);
    checkOutput("inc_idle_none", incCount, 0);
    tap(4'b0001);
    tap(4'b0100);
    checkOutput("inc_write_count", incCount, 1);
    checkOutput("inc_write_gap", (incTimes.size() > 0) ? incTimes[0] - pulseFirst[2] : -1, 1);
    tap(4'b1000);
    checkOutput("dec_write_count", decCount, 1);
    tap(4'b1100);
    checkOutput("incdec_both_inc", incCount, 0);
    checkOutput("incdec_both_dec", decCount, 0);
    tap(4'b0001);
    tap(4'b0100);
    checkOutput("inc_read_none", incCount, 0);
    tap(4'b0001);
    checkOutput("gating_back_idle", mode, 0);

    // Mode pulse beats a simultaneous decrement pulse.
    tap(4'b0001);
    tap(4'b1001);
    checkOutput("prio_mode_read", mode, 2);
    checkOutput("prio_no_dec", decCount, 0);
    tap(4'b0001);

    // Hold-to-repeat: initial command at cycle 8, then every 5 cycles.
    tap(4'b0001);
    applyStimulus(4'b0100, 0, 20);
    checkOutput("repeat_count", incCount, 3);
    checkOutput("repeat_t0", (incTimes.size() > 0) ? incTimes[0] : -1, 8);
    checkOutput("repeat_t1", (incTimes.size() > 1) ? incTimes[1] : -1, 13);
    checkOutput("repeat_t2", (incTimes.size() > 2) ? incTimes[2] : -1, 18);

    // Reset mid-hold clears outputs without waiting for a clock edge.
    reset = 1'b1;
    #1;
    checkOutput("reset_midhold_outputs",
                int'({btn_pulse, clear, write, read, enable_increment,
                      enable_decrement, output_select, mode}), 0);
    repeat (2) @(posedge hwclk);
    #1;
    reset = 1'b0;

    // Still held after reset: re-debounced pulse in IDLE, no commands.
    applyStimulus(4'b0100, 0, 20);
    checkOutput("post_reset_pulse", pulseCount[2], 1);
    checkOutput("post_reset_no_inc", incCount, 0);
    checkOutput("post_reset_idle", mode, 0);
    applyStimulus(4'b0000, 0, 12);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
